// File: rtl/max_cut_scan_if.sv
// Handshake and result bundle between the max-cut candidate scanner and its environment.
// The master side drives start/abort and the checker verdict; the slave side is the scanner.
interface max_cut_scan_if;
  logic       start;
  logic       abort;
  logic [4:0] cand;
  logic       chk_result;
  logic       busy;
  logic       done;
  logic       found;
  logic [4:0] first_cand;
  logic [5:0] hit_count;

  modport master (
    output start, abort, chk_result,
    input  cand, busy, done, found, first_cand, hit_count
  );

  modport slave (
    input  start, abort, chk_result,
    output cand, busy, done, found, first_cand, hit_count
  );
endinterface

// File: rtl/max_cut_scan.sv
// Exhaustive scanner over 5-node partitions: drives each candidate to an external
// combinational max-cut checker, samples its verdict and accumulates hit statistics.
module max_cut_scan #(
  parameter bit SKIP_SYM   = 1'b0,
  parameter bit STOP_FIRST = 1'b0
) (
  input logic          clk,
  input logic          rst,
  max_cut_scan_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  // A cut and its complement are equivalent, so half the space suffices when SKIP_SYM is set.
  localparam logic [4:0] LAST_CAND = SKIP_SYM ? 5'd15 : 5'd31;
  localparam logic [5:0] MAX_HITS  = 6'd32;

  state_t     state;
  logic [4:0] cand;
  logic       busy;
  logic       done;
  logic       found;
  logic [4:0] first_cand;
  logic [5:0] hit_count;

  assign bus.cand       = cand;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.found      = found;
  assign bus.first_cand = first_cand;
  assign bus.hit_count  = hit_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cand       <= 5'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      first_cand <= 5'd0;
      hit_count  <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            state      <= DRIVE;
            cand       <= 5'd0;
            busy       <= 1'b1;
            found      <= 1'b0;
            first_cand <= 5'd0;
            hit_count  <= 6'd0;
          end
        end

        DRIVE: begin
          if (bus.abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          // Abort discards the verdict being sampled in this same cycle.
          if (bus.abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (bus.chk_result) begin
              if (hit_count != MAX_HITS) begin
                hit_count <= hit_count + 6'd1;
              end
              if (!found) begin
                found      <= 1'b1;
                first_cand <= cand;
              end
            end
            if (cand == LAST_CAND || (STOP_FIRST && bus.chk_result)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cand  <= cand + 5'd1;
              state <= DRIVE;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_cut_scan.sv
// Randomized bench for max_cut_scan: three parameter variants scanned side by side against a
// behavioural model that walks the candidate list and predicts per-cycle and final outputs.
module tb_max_cut_scan;

  logic        clk;
  logic        rst;
  logic [31:0] hit_mask;
  logic        start_sig [3];
  logic        abort_sig [3];

  logic        obs_busy  [3];
  logic        obs_done  [3];
  logic        obs_found [3];
  logic [4:0]  obs_cand  [3];
  logic [4:0]  obs_first [3];
  logic [5:0]  obs_count [3];

  int exp_end    [3];
  int exp_done_c [3];
  int exp_win    [3];
  int exp_found  [3];
  int exp_first  [3];
  int exp_count  [3];
  int exp_cand   [3];

  int check_count = 0;
  int pass_count  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Variant 0: defaults, variant 1: SKIP_SYM, variant 2: STOP_FIRST.
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    max_cut_scan_if bus ();

    assign bus.start      = start_sig[g];
    assign bus.abort      = abort_sig[g];
    assign bus.chk_result = hit_mask[bus.cand];

    assign obs_busy[g]  = bus.busy;
    assign obs_done[g]  = bus.done;
    assign obs_found[g] = bus.found;
    assign obs_cand[g]  = bus.cand;
    assign obs_first[g] = bus.first_cand;
    assign obs_count[g] = bus.hit_count;

    max_cut_scan #(
      .SKIP_SYM   (g == 1),
      .STOP_FIRST (g == 2)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Predicts the scan outcome by walking candidates: candidate k is sampled at cycle 2k+2.
  task automatic buildModel(input logic [31:0] mask, input int abort_at);
    int last;
    int aborted;
    for (int i = 0; i < 3; i++) begin
      last          = (i == 1) ? 15 : 31;
      aborted       = 0;
      exp_found[i]  = 0;
      exp_first[i]  = 0;
      exp_count[i]  = 0;
      exp_cand[i]   = 0;
      exp_done_c[i] = 0;
      for (int k = 0; k <= last; k++) begin
        if (abort_at != 0 && abort_at <= 2 * k + 2) begin
          aborted     = 1;
          exp_cand[i] = (abort_at - 1) / 2;
          break;
        end
        exp_cand[i] = k;
        if (mask[k]) begin
          exp_count[i]++;
          if (exp_found[i] == 0) begin
            exp_found[i] = 1;
            exp_first[i] = k;
          end
        end
        if (k == last || (i == 2 && mask[k])) begin
          exp_done_c[i] = 2 * k + 3;
          break;
        end
      end
      exp_end[i] = aborted ? abort_at + 1 : exp_done_c[i];
      exp_win[i] = aborted ? abort_at : exp_done_c[i];
    end
  endtask

  task automatic applyStimulus(input int c, input int abort_at, input int rst_at);
    logic after_rst;
    after_rst = (rst_at != 0 && c > rst_at);
    rst = (rst_at != 0 && c == rst_at);
    for (int i = 0; i < 3; i++) begin
      if (c <= exp_win[i] && !after_rst) start_sig[i] = 1'($urandom_range(0, 1));
      else                               start_sig[i] = 1'b0;
      if (c < exp_end[i] && !after_rst)  abort_sig[i] = (c == abort_at);
      else                               abort_sig[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic checkZero(input string where);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s busy[%0d]", where, i),  int'(obs_busy[i]),  0);
      checkOutput($sformatf("%s done[%0d]", where, i),  int'(obs_done[i]),  0);
      checkOutput($sformatf("%s cand[%0d]", where, i),  int'(obs_cand[i]),  0);
      checkOutput($sformatf("%s found[%0d]", where, i), int'(obs_found[i]), 0);
      checkOutput($sformatf("%s first[%0d]", where, i), int'(obs_first[i]), 0);
      checkOutput($sformatf("%s count[%0d]", where, i), int'(obs_count[i]), 0);
    end
  endtask

  task automatic runScan(input logic [31:0] mask, input int abort_at, input int rst_at);
    logic zeroed;
    hit_mask = mask;
    buildModel(mask, abort_at);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      start_sig[i] = 1'b1;
      abort_sig[i] = 1'($urandom_range(0, 1));
    end
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      zeroed = (rst_at != 0 && c > rst_at);
      if (zeroed && c == rst_at + 1) begin
        checkZero($sformatf("rst@%0d", c));
      end
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("busy[%0d]@%0d", i, c), int'(obs_busy[i]),
                    int'(!zeroed && c < exp_end[i]));
        checkOutput($sformatf("done[%0d]@%0d", i, c), int'(obs_done[i]),
                    int'(!zeroed && c == exp_done_c[i]));
        if (!zeroed && c < exp_end[i]) begin
          checkOutput($sformatf("cand[%0d]@%0d", i, c), int'(obs_cand[i]), (c - 1) / 2);
        end
      end
      applyStimulus(c, abort_at, rst_at);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_sig[i] = 1'b0;
      abort_sig[i] = 1'b0;
    end
    @(negedge clk);
    zeroed = (rst_at != 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("final found[%0d]", i), int'(obs_found[i]), zeroed ? 0 : exp_found[i]);
      checkOutput($sformatf("final first[%0d]", i), int'(obs_first[i]), zeroed ? 0 : exp_first[i]);
      checkOutput($sformatf("final count[%0d]", i), int'(obs_count[i]), zeroed ? 0 : exp_count[i]);
      checkOutput($sformatf("final cand[%0d]", i),  int'(obs_cand[i]),  zeroed ? 0 : exp_cand[i]);
    end
  endtask

  initial begin
    logic [31:0] stub;
    logic [31:0] rnd_mask;
    int          rnd_abort;
    stub     = (32'd1 << 11) | (32'd1 << 20);
    hit_mask = 32'd0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_sig[i] = 1'b1;
      abort_sig[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    checkZero("reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_sig[i] = 1'b0;
      abort_sig[i] = 1'b0;
    end
    @(negedge clk);

    runScan(stub, 0, 0);
    runScan(stub, 30, 0);
    runScan(stub, 0, 20);
    runScan(stub, 0, 0);
    runScan(32'd0, 0, 0);
    runScan(32'hFFFF_FFFF, 0, 0);

    for (int t = 0; t < 8; t++) begin
      rnd_mask  = $urandom & $urandom;
      rnd_abort = (t % 2 == 1) ? int'($urandom_range(1, 64)) : 0;
      runScan(rnd_mask, rnd_abort, 0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/max_cut_scan.md
MAX_CUT_SCAN -- requirements
Module: max_cut_scan

Interface
REQ-001 Parameter SKIP_SYM, default 0: when 1, scan only candidates with cand[4]=0, i.e. 0..15, exploiting complement symmetry of a cut.
REQ-002 Parameter STOP_FIRST, default 0: when 1, the scan ends at the first candidate whose sampled chk_result is 1.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: begin a scan; honoured only in IDLE.
REQ-006 Port abort, input, 1: terminate an active scan without a done pulse.
REQ-007 Port cand, output, 5: candidate partition driven to the downstream max_cut checker inputs a..e, in the order cand[0]=a .. cand[4]=e.
REQ-008 Port chk_result, input, 1: combinational verdict from the checker for the current cand.
REQ-009 Port busy, output, 1: high while in DRIVE or SAMPLE.
REQ-010 Port done, output, 1: one-cycle pulse when a scan completes normally.
REQ-011 Port found, output, 1: at least one hit in the current or last scan.
REQ-012 Port first_cand, output, 5: lowest-valued candidate that hit; 0 when found=0.
REQ-013 Port hit_count, output, 6: number of hits in the current or last scan, range 0..32.

Function
REQ-014 The FSM states SHALL be IDLE, DRIVE, SAMPLE and DONE, with exactly one state active per cycle.
REQ-015 IDLE with start=1 SHALL move to DRIVE next cycle, set cand=0, and clear found, first_cand and hit_count.
REQ-016 DRIVE SHALL hold cand stable for one full cycle so the combinational checker settles, then move to SAMPLE.
REQ-017 SAMPLE SHALL register chk_result at the end of the cycle; if it is 1, hit_count increments, and if found was 0 then found is set to 1 and first_cand is loaded with cand.
REQ-018 From SAMPLE, if cand equals the last candidate (31, or 15 when SKIP_SYM=1), or STOP_FIRST=1 and this sample hit, the next state SHALL be DONE; otherwise cand increments by 1 and the next state is DRIVE.
REQ-019 DONE SHALL assert done for exactly one cycle and then return to IDLE; cand holds its last value.
REQ-020 Each candidate SHALL take exactly 2 cycles; with start accepted at cycle 0, candidate k is in DRIVE at cycle 2k+1 and in SAMPLE at cycle 2k+2; a full scan (SKIP_SYM=0) has done=1 at cycle 65 and busy=1 for cycles 1..64.
REQ-021 start SHALL be ignored in DRIVE, SAMPLE and DONE; a start arriving in the DONE cycle is lost.
REQ-022 abort=1 in DRIVE or SAMPLE SHALL force IDLE next cycle with no done pulse; found, first_cand and hit_count keep their partial values.
REQ-023 abort SHALL take priority over a hit in the same SAMPLE cycle; that sample is discarded.
REQ-024 abort in IDLE or DONE SHALL have no effect; if start and abort are both 1 in IDLE, start wins.
REQ-025 cand SHALL never wrap: the increment from the last candidate is never performed.
REQ-026 hit_count SHALL saturate at 32, which is reachable and does not overflow 6 bits.
REQ-027 found, first_cand and hit_count SHALL remain stable in IDLE until the next accepted start.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE and clear cand, busy, done, found, first_cand and hit_count to 0, including mid-scan.
REQ-029 rst SHALL override start and abort in the same cycle.

Verification
REQ-030 Stub checker hits on cand 5'b01011 and 5'b10100, defaults, start at cycle 0 -> done at cycle 65, found=1, first_cand=11, hit_count=2.
REQ-031 Same stub, SKIP_SYM=1 -> done at cycle 33, found=1, first_cand=11, hit_count=1.
REQ-032 Same stub, STOP_FIRST=1 -> done at cycle 25 (candidate 11 sampled at cycle 24), hit_count=1, cand=11.
REQ-033 Stub always 0 -> done at cycle 65, found=0, first_cand=0, hit_count=0; stub always 1 -> hit_count=32.
REQ-034 abort at cycle 30 with first stub -> busy=0 at cycle 31, no done, found=1, first_cand=11, hit_count=1; start during busy is ignored.
REQ-035 rst at cycle 20 mid-scan -> all outputs 0 at cycle 21; a new start after that completes a normal scan with the results of REQ-030.
